t_ff_count_ctrl: RTL and testbench
==================================

Name: t_ff_count_ctrl

Overview:
- Sequencer for a bank of WIDTH toggle flip-flops wired as a synchronous up-counter.
- Generates the per-bit T (toggle-enable) vector each cycle, runs the bank from 0 up to a latched target, and supports pause, resume and clear.
- Signals completion with a one-cycle done pulse.
- Sits between a simple command source (start/stop/clear) and the T-FF bank. The bank is held inside the block; its state is exposed on q.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank; width of target and q.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset. reset=0 forces the reset state immediately, independent of clk.
- start, input, 1, begin a count (IDLE) or resume (PAUSE).
- stop, input, 1, pause the count (RUN).
- clear, input, 1, abort, zero the bank, return to IDLE.
- target, input, WIDTH, terminal count; sampled only on an accepted start in IDLE.
- q, output, WIDTH, T-FF bank state; registered.
- t_out, output, WIDTH, toggle vector applied at the next edge; combinational.
- busy, output, 1, high in RUN and PAUSE; registered/state-decoded.
- done, output, 1, one-cycle completion pulse; high only in DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, q=0, tgt_r=0, busy=0, done=0. t_out=0 while reset is asserted.
- Bank update: every edge, q <= q ^ t_out. Each bit is a T flip-flop, so no other path writes q except clear and start-load, both of which force 0.
- Toggle vector in RUN, with no stop and no clear:
  - t_out[0]=1.
  - t_out[i]=&q[i-1:0] for i>0, i.e. a +1 increment.
- t_out=0 in every other state/condition.
- Command priority, evaluated every cycle: clear > stop > start.
- States:
  - IDLE:
    - busy=0.
    - clear: q<=0, stay IDLE.
    - start: tgt_r<=target, q<=0.
      - target==0: go to DONE.
      - otherwise: go to RUN.
    - stop is ignored.
  - RUN:
    - busy=1.
    - clear: q<=0, go to IDLE; no toggle that edge.
    - stop: go to PAUSE; no toggle that edge; q holds.
    - otherwise: increment.
      - If (q+1)==tgt_r, go to DONE on the same edge that q becomes tgt_r.
      - Otherwise stay in RUN.
    - start is ignored; the target is not reloaded.
  - PAUSE:
    - busy=1, t_out=0.
    - clear: q<=0, go to IDLE.
    - start (with stop=0): go to RUN; tgt_r is kept; counting resumes from the held q.
    - stop alone: stay in PAUSE.
  - DONE:
    - done=1, busy=0, q holds tgt_r, for exactly one cycle.
    - Next edge: go to IDLE.
    - start is ignored. clear zeroes q.
- Latency, for start accepted at edge k with target=N>0:
  - first toggle at edge k+1;
  - q==N after edge k+N;
  - done high during the cycle after edge k+N.
  - Each stop cycle adds at least one cycle.
- Arithmetic: the terminal compare is WIDTH bits with no wrap. target=2^WIDTH-1 is legal; the bank never passes through the all-ones to 0 wrap while in RUN.
- Simultaneous events:
  - stop+start in PAUSE: stay in PAUSE.
  - clear with anything: clear wins.
  - stop on the cycle q would reach tgt_r: pause; q stays tgt_r-1.
- Mid-operation reset (reset=0 in RUN/PAUSE/DONE): immediate return to the reset values; no done pulse.

Test Plan:
- Reset, WIDTH=4: hold reset=0 for 2 cycles, then release -> q=0000, busy=0, done=0, t_out=0000. Assert reset=0 between edges -> q clears without waiting for clk.
- Basic count: target=5, pulse start -> busy=1 next cycle; q steps 1,2,3,4,5 on successive edges; done=1 for exactly one cycle with q=0101; then IDLE with busy=0 and q held at 0101. t_out sequence matches 0001,0011,0001,0111,0001.
- Pause/resume: target=9, start; stop when q=3, held for 3 cycles -> q stays 0011, t_out=0000, busy=1. Then start -> q continues 4..9, done after 6 more edges.
- Clear priority: in RUN at q=6, assert clear+stop together -> q=0000 and IDLE next edge, no done. Clear in PAUSE behaves the same.
- Boundaries:
  - target=0 with start -> DONE next cycle, done=1, q=0000, no toggles.
  - target=15 -> q reaches 1111 after 15 edges, then done; q does not wrap to 0.
- Ignored commands: start during RUN (target input changed to 2) -> count still ends at the original tgt_r. Start during DONE -> returns to IDLE, no new run.

Source files
------------

// File: rtl/t_ff_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : t_ff_count_ctrl
//  Purpose  : Sequencer for a bank of WIDTH toggle flip-flops wired as a
//             synchronous up-counter. Counts the bank from zero up to a
//             latched target, supports pause/resume/clear, and raises a
//             one-cycle done pulse when the target is reached.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in   1      rising-edge clock
//    reset   in   1      asynchronous, active-low reset
//    start   in   1      begin a count (IDLE) or resume (PAUSE)
//    stop    in   1      pause the count (RUN)
//    clear   in   1      abort, zero the bank, return to IDLE
//    target  in   WIDTH  terminal count, sampled on an accepted start in IDLE
//    q       out  WIDTH  T-FF bank state (registered)
//    t_out   out  WIDTH  toggle vector applied at the next edge (combinational)
//    busy    out  1      high in RUN and PAUSE (registered)
//    done    out  1      one-cycle completion pulse (registered)
// ============================================================================
module t_ff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt_r;

  // Ripple-carry of the bank: carry[i] is high when every lower bit is 1,
  // which is exactly the toggle condition for bit i in a +1 increment.
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] q_inc;
  logic             counting;
  logic             zero_bank;
  logic             hit_target;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign carry[gi] = carry[gi-1] & q[gi-1];
    end
  endgenerate

  // Toggling happens only in RUN with no stop/clear pending. Gating with
  // reset keeps t_out quiet while the block is held in reset.
  assign counting  = reset && (state == ST_RUN) && !clear && !stop;
  assign t_out     = counting ? carry : '0;

  // The only non-toggle writes to the bank: clear in any state, and the
  // start-load in IDLE. Both force zero.
  assign zero_bank = clear || ((state == ST_IDLE) && start);

  // q ^ carry is q+1 in WIDTH bits; it is only compared while in RUN, where
  // q is always strictly below tgt_r, so the wrap case never matters.
  assign q_inc      = q ^ carry;
  assign hit_target = (q_inc == tgt_r);

  // --------------------------------------------------------------------------
  // T flip-flop bank: one flop per bit, each toggling on its t_out bit.
  // --------------------------------------------------------------------------
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tff
      logic bit_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          bit_q <= 1'b0;
        end else if (zero_bank) begin
          bit_q <= 1'b0;
        end else if (t_out[gi]) begin
          bit_q <= ~bit_q;
        end
      end

      assign q[gi] = bit_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM. busy and done are registered alongside the state so they
  // change on the same edge as the state they describe.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      tgt_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              tgt_r <= target;
              if (target == '0) begin
                // Nothing to count: report completion straight away.
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= ST_RUN;
                busy  <= 1'b1;
              end
            end
          end

          ST_RUN: begin
            if (stop) begin
              state <= ST_PAUSE;
            end else if (hit_target) begin
              // Leave RUN on the same edge the bank lands on tgt_r.
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end

          ST_PAUSE: begin
            if (start && !stop) begin
              state <= ST_RUN;
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t_ff_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t_ff_count_ctrl
//  Purpose  : Self-checking bench for t_ff_count_ctrl (WIDTH=4). A mode/count
//             model predicts q, t_out, busy and done every cycle; directed
//             sequences add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_t_ff_count_ctrl;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         start  = 1'b0;
  logic         stop   = 1'b0;
  logic         clear  = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] q;
  logic [W-1:0] t_out;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  t_ff_count_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .clear  (clear),
    .target (target),
    .q      (q),
    .t_out  (t_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int m_mode = M_IDLE;
  int m_q    = 0;
  int m_tgt  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE;
      m_q    = 0;
      m_tgt  = 0;
    end else if (clear) begin
      m_mode = M_IDLE;
      m_q    = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_tgt  = int'(target);
          m_q    = 0;
          m_mode = (m_tgt == 0) ? M_DONE : M_RUN;
        end
        M_RUN: begin
          if (stop) m_mode = M_PAUSE;
          else begin
            m_q = m_q + 1;
            if (m_q == m_tgt) m_mode = M_DONE;
          end
        end
        M_PAUSE: if (start && !stop) m_mode = M_RUN;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  function automatic int exp_t();
    if (reset && m_mode == M_RUN && !clear && !stop)
      return ((m_q + 1) ^ m_q) & MASK;
    return 0;
  endfunction

  always @(negedge clk) begin
    chk("model_q",     32'(q),     32'(m_q));
    chk("model_t_out", 32'(t_out), 32'(exp_t()));
    chk("model_busy",  32'(busy),  32'(m_mode == M_RUN || m_mode == M_PAUSE));
    chk("model_done",  32'(done),  32'(m_mode == M_DONE));
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input int tgt);
    target = W'(tgt);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic run_until_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
  endtask

  int n;
  int tv [5] = '{1, 3, 1, 7, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges, then released.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_q", 32'(q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_t_out", 32'(t_out), 0);

    // Basic count to 5.
    launch(5);
    #1;
    chk("basic_busy", 32'(busy), 1);
    chk("basic_q0", 32'(q), 0);
    chk("basic_t0", 32'(t_out), 32'(tv[0]));
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("basic_q", 32'(q), 32'(i));
      chk("basic_t", 32'(t_out), 32'(tv[i]));
    end
    tick();
    chk("basic_done_q", 32'(q), 5);
    chk("basic_done", 32'(done), 1);
    chk("basic_done_busy", 32'(busy), 0);
    tick();
    chk("basic_after_done", 32'(done), 0);
    chk("basic_after_busy", 32'(busy), 0);
    chk("basic_after_q", 32'(q), 5);

    // Pause at 3 for three cycles, then resume to 9.
    launch(9);
    repeat (3) tick();
    chk("pause_q_pre", 32'(q), 3);
    stop = 1'b1;
    #1 chk("pause_t_now", 32'(t_out), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_q", 32'(q), 3);
      chk("pause_busy", 32'(busy), 1);
      chk("pause_t", 32'(t_out), 0);
    end
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_q", 32'(q), 3);
    run_until_done(20, n);
    chk("resume_edges", 32'(n), 6);
    chk("resume_q_end", 32'(q), 9);
    tick();

    // clear+stop while running at 6.
    launch(9);
    repeat (6) tick();
    chk("clr_q_pre", 32'(q), 6);
    clear = 1'b1;
    stop  = 1'b1;
    tick();
    clear = 1'b0;
    stop  = 1'b0;
    chk("clr_q", 32'(q), 0);
    chk("clr_busy", 32'(busy), 0);
    tick();
    chk("clr_no_done", 32'(done), 0);

    // clear while paused.
    launch(9);
    repeat (2) tick();
    stop = 1'b1;
    tick();
    chk("clrp_busy", 32'(busy), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    stop  = 1'b0;
    chk("clrp_q", 32'(q), 0);
    chk("clrp_busy_after", 32'(busy), 0);

    // target = 0: straight to DONE.
    launch(0);
    chk("t0_done", 32'(done), 1);
    chk("t0_q", 32'(q), 0);
    chk("t0_t", 32'(t_out), 0);
    tick();
    chk("t0_after", 32'(done), 0);

    // target = 15: full range, no wrap.
    launch(15);
    run_until_done(40, n);
    chk("t15_edges", 32'(n), 15);
    chk("t15_q", 32'(q), 15);
    tick();
    chk("t15_hold", 32'(q), 15);
    chk("t15_idle_busy", 32'(busy), 0);

    // stop on the edge that would reach the target.
    launch(3);
    repeat (2) tick();
    stop = 1'b1;
    tick();
    chk("stoplast_q", 32'(q), 2);
    chk("stoplast_done", 32'(done), 0);
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("stoplast_q_end", 32'(q), 3);
    chk("stoplast_done_end", 32'(done), 1);
    tick();

    // start during RUN with a new target is ignored; start during DONE too.
    launch(7);
    tick();
    target = 4'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("ign_busy", 32'(busy), 1);
    run_until_done(20, n);
    chk("ign_q", 32'(q), 7);
    chk("ign_done", 32'(done), 1);
    target = 4'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("ign_done_busy", 32'(busy), 0);
    chk("ign_done_q", 32'(q), 7);
    tick();
    chk("ign_done_busy2", 32'(busy), 0);
    chk("ign_done_q2", 32'(q), 7);

    // Asynchronous reset between edges while running.
    launch(9);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("areset_q", 32'(q), 0);
    chk("areset_busy", 32'(busy), 0);
    chk("areset_t", 32'(t_out), 0);
    tick();
    reset = 1'b1;
    #1;
    chk("areset_rel_q", 32'(q), 0);
    chk("areset_rel_done", 32'(done), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
